// File: rtl/spi_ctrl_pkg.sv
// Shared SPI control definitions: master FSM states, SPI mode constants and
// the DDS control word width used by the DDS/DAC related blocks.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam bit MODE_CPOL0 = 1'b0;
    localparam bit MODE_CPOL1 = 1'b1;
    localparam bit MODE_CPHA0 = 1'b0;

    localparam int unsigned DDS_CTRL_W = 16;

    // Index width for n channels, never below one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/spi_dac_cmd_master_if.sv
// Command handshake between the register/control block and the SPI master.
interface spi_dac_cmd_if
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DDS_CTRL_W,
    parameter int unsigned CS_W   = 1
);
    logic [DATA_W-1:0] cmd_data;
    logic [CS_W-1:0]   cmd_cs;
    logic              cmd_valid;
    logic              cmd_ready;

    modport master (output cmd_data, cmd_cs, cmd_valid, input cmd_ready);
    modport slave  (input cmd_data, cmd_cs, cmd_valid, output cmd_ready);
endinterface

// File: rtl/spi_dac_cmd_master_sync_fifo.sv
// Small synchronous FIFO with registered ready/empty/level; read data is
// presented combinationally from the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int unsigned AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             empty_q, empty_d;
    logic             push, pop;

    assign push      = wr_valid && ready_q;
    assign pop       = rd_en && !empty_q;
    assign wr_ready  = ready_q;
    assign empty     = empty_q;
    assign level     = cnt_q;
    assign rd_data_c = mem_q[rd_ptr_q];

    // Pointer/count update; flags are registered from the next count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_d   = cnt_q + LVL_W'(push) - LVL_W'(pop);
        ready_d = (cnt_d != LVL_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/spi_dac_cmd_master.sv
// Multi-channel SPI write master for DDS/DAC control words: command FIFO,
// per-word chip select, programmable SCK divider and per-channel suppression
// of repeated words.
module spi_dac_cmd_master
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = DDS_CTRL_W,
    parameter int unsigned NUM_CS     = 2,
    parameter int unsigned CS_W       = clog2_min1(NUM_CS),
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CS_GAP     = 2,
    parameter bit          CPOL       = MODE_CPOL0,
    parameter bit          DEDUP      = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    spi_dac_cmd_if.slave      cmd,
    output logic              sck,
    output logic              mosi,
    output logic [NUM_CS-1:0] ss_n,
    output logic              busy,
    output logic              word_done,
    output logic              word_drop,
    output logic              cs_err
);
    localparam int unsigned ENTRY_W = CS_W + DATA_W;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned EDGE_W  = $clog2(2 * DATA_W + 1);
    localparam int unsigned SH_N    = 1 << CS_W;
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  GAP_LAST  = DIV_W'(CS_GAP - 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    localparam logic [CS_W:0]     NUM_CS_L  = (CS_W + 1)'(NUM_CS);

    logic [ENTRY_W-1:0] fifo_rd_data_c;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic               pop_c, push_c, cs_ok_c;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [CS_W-1:0]     cs_q, cs_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [NUM_CS-1:0]   ss_n_q, ss_n_d;
    logic                busy_q, busy_d;
    logic                word_done_q, word_done_d;
    logic                word_drop_q, word_drop_d;
    logic                cs_err_q, cs_err_d;
    logic [DATA_W-1:0]   shadow_q [SH_N];
    logic [DATA_W-1:0]   shadow_d [SH_N];
    logic [SH_N-1:0]     shadow_valid_q, shadow_valid_d;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_data   ({cmd.cmd_cs, cmd.cmd_data}),
        .wr_valid  (cmd.cmd_valid),
        .wr_ready  (cmd.cmd_ready),
        .rd_en     (pop_c),
        .rd_data_c (fifo_rd_data_c),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign pop_c   = (state_q == ST_IDLE) && !fifo_empty;
    assign push_c  = cmd.cmd_valid && cmd.cmd_ready;
    assign cs_ok_c = ({1'b0, cs_q} < NUM_CS_L);

    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign ss_n      = ss_n_q;
    assign busy      = busy_q;
    assign word_done = word_done_q;
    assign word_drop = word_drop_q;
    assign cs_err    = cs_err_q;

    // Word sequencing: pop, check channel/dedup, then frame and shift the word.
    always_comb begin
        state_d        = state_q;
        div_d          = div_q;
        edge_d         = edge_q;
        shreg_d        = shreg_q;
        word_d         = word_q;
        cs_d           = cs_q;
        sck_d          = sck_q;
        mosi_d         = mosi_q;
        ss_n_d         = ss_n_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        word_done_d    = 1'b0;
        word_drop_d    = 1'b0;
        cs_err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    {cs_d, word_d} = fifo_rd_data_c;
                    shreg_d        = fifo_rd_data_c[DATA_W-1:0];
                    state_d        = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!cs_ok_c) begin
                    cs_err_d    = 1'b1;
                    word_drop_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (DEDUP && shadow_valid_q[cs_q] && (shadow_q[cs_q] == word_q)) begin
                    word_drop_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    ss_n_d  = ~(NUM_CS'(1) << cs_q);
                    mosi_d  = shreg_q[DATA_W-1];
                    div_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    edge_d  = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sck_d  = ~sck_q;
                    edge_d = edge_q + EDGE_W'(1);
                    // Odd toggles return sck to idle: launch the next bit there.
                    if (edge_q[0]) begin
                        if (edge_q == LAST_EDGE) begin
                            state_d = ST_HOLD;
                        end else begin
                            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                            mosi_d  = shreg_d[DATA_W-1];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d                  = '0;
                    ss_n_d                 = '1;
                    mosi_d                 = 1'b0;
                    shadow_d[cs_q]         = word_q;
                    shadow_valid_d[cs_q]   = 1'b1;
                    word_done_d            = 1'b1;
                    state_d                = ST_GAP;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || push_c || (fifo_level > LVL_W'(pop_c));
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            div_q          <= '0;
            edge_q         <= '0;
            shreg_q        <= '0;
            word_q         <= '0;
            cs_q           <= '0;
            sck_q          <= CPOL;
            mosi_q         <= 1'b0;
            ss_n_q         <= '1;
            busy_q         <= 1'b0;
            word_done_q    <= 1'b0;
            word_drop_q    <= 1'b0;
            cs_err_q       <= 1'b0;
            shadow_q       <= '{default: '0};
            shadow_valid_q <= '0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            edge_q         <= edge_d;
            shreg_q        <= shreg_d;
            word_q         <= word_d;
            cs_q           <= cs_d;
            sck_q          <= sck_d;
            mosi_q         <= mosi_d;
            ss_n_q         <= ss_n_d;
            busy_q         <= busy_d;
            word_done_q    <= word_done_d;
            word_drop_q    <= word_drop_d;
            cs_err_q       <= cs_err_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

endmodule
